// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  // Port identifiers, also the encoding of err_src.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Byte enables as produced by the pipeline controller for loads/stores.
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H    = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Saturating increment for the data-run counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the memory.
// slave: the arbiter's view. master: the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_N = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              d_req;
  logic [BE_N-1:0]   d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              mem_req;
  logic [BE_N-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              err_timeout;
  logic              err_src;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err_timeout, err_src
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err_timeout, err_src
  );

endinterface

// File: rtl/mem_port_arbiter_arb_watchdog.sv
// Transaction watchdog: counts BUSY cycles without a memory completion and
// aborts the transaction when the count reaches TIMEOUT (0 = disabled).
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic mem_ready,
  output logic abort,
  output logic err_timeout
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             err_timeout_q, err_timeout_d;

  // Abort fires in the BUSY cycle whose stall would bring the count to TIMEOUT.
  always_comb begin
    cnt_inc       = {1'b0, cnt_q} + (CNT_W+1)'(1);
    abort         = (TIMEOUT != 0) && busy && !mem_ready && (cnt_inc == LIMIT);
    cnt_d         = cnt_q;
    if (!busy || abort) cnt_d = '0;
    else if (!mem_ready) cnt_d = cnt_inc[CNT_W-1:0];
    err_timeout_d = abort;
  end

  // Counter and one-cycle abort pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and data (D) ports.
// Data wins by default since it belongs to the older instruction; a run
// counter lets fetch through after MAX_D_RUN back-to-back data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_D_RUN = 4,
  parameter int TIMEOUT   = 255
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_N = DATA_W / 8;
  localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [BE_N-1:0]   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        run_q, run_d;
  logic              err_src_q, err_src_d;
  logic              i_ready, d_ready;
  logic              busy, abort, err_timeout;

  assign busy = (state_q != IDLE);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy),
    .mem_ready   (bus.mem_ready),
    .abort       (abort),
    .err_timeout (err_timeout)
  );

  // Arbitration, transaction sequencing and response routing.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    run_d       = run_q;
    err_src_d   = err_src_q;
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (bus.d_req && !(bus.i_req && run_q == RUN_MAX)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          run_d       = bus.i_req ? sat_inc4(run_q, RUN_MAX) : 4'd0;
        end else if (bus.i_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = '0;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = '0;
          run_d       = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) begin
          i_ready   = (state_q == BUSY_I);
          d_ready   = (state_q == BUSY_D);
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (abort) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_src_d = (state_q == BUSY_D) ? PORT_D : PORT_I;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and latched memory request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      run_q       <= 4'd0;
      err_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      run_q       <= run_d;
      err_src_q   <= err_src_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_ready     = i_ready;
  assign bus.d_ready     = d_ready;
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;
  assign bus.i_stall     = bus.i_req && !i_ready;
  assign bus.d_stall     = bus.d_req && !d_ready;
  assign bus.err_timeout = err_timeout;
  assign bus.err_src     = err_src_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the F-stage instruction fetch port and the M-stage data port of the RV32I 5-stage pipeline.
- Arbitrates between the two ports, latches the winning request, sequences the memory transaction, and routes the response back.
- Emits per-port stall signals that the pipeline controller ORs into its stall/freeze logic.
- Includes a fairness counter and a transaction watchdog.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits (4).
- MAX_D_RUN, 4, max consecutive data grants while i_req is pending before instruction wins one grant (1..15).
- TIMEOUT, 255, cycles allowed in a BUSY state before abort; 0 disables the watchdog.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- i_req  input  1  fetch request, held until i_ready
- i_addr  input  ADDR_W  fetch word address, stable while i_req
- i_ready  output  1  fetch completed this cycle
- i_rdata  output  DATA_W  fetch data, valid when i_ready
- i_stall  output  1  i_req && !i_ready
- d_req  input  1  data request, held until d_ready
- d_we  input  4  byte write enables (0000 = load; 0001/0011/1111 = sb/sh/sw)
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_ready  output  1  data access completed this cycle
- d_rdata  output  DATA_W  load data, valid when d_ready
- d_stall  output  1  d_req && !d_ready
- mem_req  output  1  memory request, held until mem_ready or abort
- mem_we  output  4  latched byte enables
- mem_addr  output  ADDR_W  latched address
- mem_wdata  output  DATA_W  latched store data
- mem_ready  input  1  memory completion pulse (1 cycle)
- mem_rdata  input  DATA_W  read data, valid with mem_ready
- err_timeout  output  1  one-cycle pulse on watchdog abort
- err_src  output  1  port of the aborted transaction (0 = I, 1 = D), held until the next abort

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - State = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, err_timeout, err_src = 0.
  - Run counter = 0; watchdog counter = 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Pick a winner from d_req/i_req (rules below).
  - Latch the winner's addr/we/wdata into the mem_* registers; fetch grants force mem_we = 0.
  - Go to BUSY_x next cycle with mem_req = 1 (registered).
  - No request: stay in IDLE, mem_req = 0.
- Arbitration:
  - Data has priority, because it belongs to the older instruction.
  - Exception: if i_req && d_req and run counter == MAX_D_RUN, grant instruction.
  - Run counter increments on each data grant while i_req = 1.
  - Run counter clears on any instruction grant, and on a data grant while i_req = 0.
  - Run counter saturates at MAX_D_RUN.
- BUSY_x:
  - mem_* outputs hold constant.
  - On mem_ready: assert x_ready combinationally the same cycle and pass mem_rdata through to x_rdata.
  - Next cycle: mem_req = 0, state = IDLE.
  - This gives one mandatory bubble between transactions; requesters drop or renew x_req in the cycle after x_ready.
- Latency: from x_req rising in IDLE with no contention, x_ready arrives 1 + L cycles later, where L = memory cycles from mem_req to mem_ready (L ≥ 0 counted from first mem_req cycle).
- The non-granted port's ready is always 0. i_rdata and d_rdata are driven by mem_rdata at all times; they are meaningful only with their ready.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - If the count reaches TIMEOUT (and TIMEOUT ≠ 0): drop mem_req, go to IDLE, pulse err_timeout, set err_src.
  - No x_ready is given; the requester stays stalled and is re-arbitrated.
- mem_ready arriving in IDLE is ignored.
- Reset mid-transaction: immediate return to the reset values, with no ready pulse.
- Address/we change while in BUSY is ignored; the latched values are used.

Decomposition:
- Shared package: state encoding (IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2), port IDs (PORT_I = 0, PORT_D = 1), byte-enable constants BE_B/BE_H/BE_W matching the controller's store enables.
- One sub-module, arb_watchdog: counter, TIMEOUT compare, and abort pulse.

Test Plan:
- i_req, i_addr = 0x100, mem_ready after 2 cycles, rdata 0x00500093 -> mem_req from cycle 1, mem_addr = 0x100, mem_we = 0; i_ready + i_rdata = 0x00500093 at cycle 3; d_ready stays 0.
- i_req and d_req rise together, d_we = 0011, d_addr = 0x204, d_wdata = 0xBEEF, L = 0 -> data granted first (mem_we = 0011, mem_wdata = 0xBEEF); after one bubble, instruction is granted; i_stall stays high throughout.
- d_req held continuously with renewed requests, i_req = 1, MAX_D_RUN = 4 -> grant order D,D,D,D,I,D...; run counter returns to 0 after the I grant.
- BUSY_D with mem_ready never asserted, TIMEOUT = 8 -> mem_req drops after 8 BUSY cycles; one-cycle err_timeout with err_src = 1; state IDLE; re-grant next cycle since d_req is still high.
- rst asserted mid-BUSY_I -> mem_req = 0 and state IDLE asynchronously; no i_ready; a later mem_ready pulse is ignored.
- Changing d_addr from 0x10 to 0x20 during BUSY_D, then mem_ready -> mem_addr stays 0x10 throughout; d_ready pulses exactly once.
